// File: rtl/io_mux_arbiter_pkg.sv
// Shared types and constants for the pad ownership arbiter.
package io_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  localparam int SEL_W    = 4;
  localparam int MAX_PINS = 16;

endpackage

// File: rtl/io_mux_arbiter_if.sv
// Bundle of requester, io_mux and pad buffer signals around the arbiter.
interface io_mux_arbiter_if #(
  parameter int N = 8
);

  logic [N-1:0]                 req;
  logic [N-1:0]                 gnt;
  logic [io_mux_pkg::SEL_W-1:0] sel;
  logic                         sel_valid;
  logic                         mux_o;
  logic                         mux_t;
  logic                         pad_o;
  logic                         pad_t;

  modport master (
    input  req, mux_o, mux_t,
    output gnt, sel, sel_valid, pad_o, pad_t
  );

  modport slave (
    output req, mux_o, mux_t,
    input  gnt, sel, sel_valid, pad_o, pad_t
  );

endinterface

// File: rtl/io_mux_arbiter_rr_pick.sv
// Round-robin winner search: rotate by the pointer, take the lowest set bit,
// then map the rotated index back onto the original request numbering.
module rr_pick
  import io_mux_pkg::*;
#(
  parameter int N = MAX_PINS
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             any_o,
  output logic [SEL_W-1:0] winner_o
);

  localparam logic [SEL_W:0] NW = (SEL_W + 1)'(N);

  logic [N-1:0]     rot_s;
  logic [SEL_W-1:0] idx_s;
  logic [SEL_W:0]   sum_s;

  // A shift by N (pointer at 0) yields zero, so the OR leaves req_i unrotated.
  assign rot_s = (req_i >> ptr_i) | (req_i << (NW - {1'b0, ptr_i}));

  // Priority encoder: lowest set bit of the rotated vector wins.
  always_comb begin
    idx_s = {SEL_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx_s = rot_s[i] ? SEL_W'(i) : idx_s;
    end
  end

  assign sum_s    = {1'b0, idx_s} + {1'b0, ptr_i};
  assign winner_o = (sum_s >= NW) ? SEL_W'(sum_s - NW) : SEL_W'(sum_s);
  assign any_o    = |req_i;

endmodule

// File: rtl/io_mux_arbiter.sv
// Pad ownership controller: round-robin grants, forced high-Z turnaround
// between owners and optional preemption of long-holding owners.
module io_mux_arbiter
  import io_mux_pkg::*;
#(
  parameter int C_NUM_OF_PIN = 8,
  parameter int C_TURNAROUND = 2,
  parameter int C_MAX_HOLD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  io_mux_arbiter_if.master mux_if
);

  localparam int TURN_W = (C_TURNAROUND > 1) ? $clog2(C_TURNAROUND) : 1;
  localparam int HOLD_W = (C_MAX_HOLD > 1) ? $clog2(C_MAX_HOLD) : 1;
  localparam logic [TURN_W-1:0]       TURN_LOAD  = TURN_W'(C_TURNAROUND - 1);
  localparam logic [HOLD_W-1:0]       HOLD_LAST  = HOLD_W'((C_MAX_HOLD > 0) ? C_MAX_HOLD - 1 : 0);
  localparam logic [SEL_W-1:0]        LAST_PIN   = SEL_W'(C_NUM_OF_PIN - 1);
  localparam logic [C_NUM_OF_PIN-1:0] GNT_LSB    = C_NUM_OF_PIN'(1);
  localparam bit                      PREEMPT_EN = (C_MAX_HOLD != 0);

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [C_NUM_OF_PIN-1:0] gnt_q, gnt_d;
  logic                    sel_valid_q, sel_valid_d;
  logic [SEL_W-1:0]        ptr_q, ptr_d;
  logic [TURN_W-1:0]       turn_cnt_q, turn_cnt_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;

  logic [C_NUM_OF_PIN-1:0] req_s;
  logic                    any_s;
  logic [SEL_W-1:0]        winner_s;
  logic                    owner_req_s;
  logic                    others_s;
  logic                    preempt_s;
  logic                    leave_s;
  logic                    turn_done_s;
  logic [SEL_W-1:0]        ptr_next_s;

  assign req_s = mux_if.req;

  rr_pick #(
    .N (C_NUM_OF_PIN)
  ) u_rr_pick (
    .req_i    (req_s),
    .ptr_i    (ptr_q),
    .any_o    (any_s),
    .winner_o (winner_s)
  );

  // gnt_q is one-hot on sel_q while owning, so masking avoids a variable index.
  assign owner_req_s = |(req_s & gnt_q);
  assign others_s    = |(req_s & ~gnt_q);
  assign preempt_s   = PREEMPT_EN && (hold_cnt_q == HOLD_LAST) && others_s;
  assign leave_s     = !owner_req_s || preempt_s;
  assign turn_done_s = (turn_cnt_q == {TURN_W{1'b0}});
  assign ptr_next_s  = (sel_q == LAST_PIN) ? {SEL_W{1'b0}} : sel_q + SEL_W'(1'b1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = any_s ? OWN : IDLE;
      end
      OWN: begin
        state_d = leave_s ? TURN : OWN;
      end
      TURN: begin
        if (turn_done_s) begin
          state_d = any_s ? OWN : IDLE;
        end else begin
          state_d = TURN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, pointer and counters.
  always_comb begin
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    sel_valid_d = sel_valid_q;
    ptr_d       = ptr_q;
    turn_cnt_d  = turn_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          sel_d       = winner_s;
          gnt_d       = GNT_LSB << winner_s;
          sel_valid_d = 1'b1;
          hold_cnt_d  = {HOLD_W{1'b0}};
        end else begin
          gnt_d       = {C_NUM_OF_PIN{1'b0}};
          sel_valid_d = 1'b0;
        end
      end
      OWN: begin
        if (leave_s) begin
          gnt_d       = {C_NUM_OF_PIN{1'b0}};
          sel_valid_d = 1'b0;
          turn_cnt_d  = TURN_LOAD;
          ptr_d       = ptr_next_s;
        end else begin
          hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1'b1);
        end
      end
      TURN: begin
        if (!turn_done_s) begin
          turn_cnt_d = turn_cnt_q - TURN_W'(1'b1);
        end else if (any_s) begin
          sel_d       = winner_s;
          gnt_d       = GNT_LSB << winner_s;
          sel_valid_d = 1'b1;
          hold_cnt_d  = {HOLD_W{1'b0}};
        end else begin
          gnt_d       = {C_NUM_OF_PIN{1'b0}};
          sel_valid_d = 1'b0;
        end
      end
      default: begin
        gnt_d       = {C_NUM_OF_PIN{1'b0}};
        sel_valid_d = 1'b0;
      end
    endcase
  end

  // Output, pointer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= {SEL_W{1'b0}};
      gnt_q       <= {C_NUM_OF_PIN{1'b0}};
      sel_valid_q <= 1'b0;
      ptr_q       <= {SEL_W{1'b0}};
      turn_cnt_q  <= {TURN_W{1'b0}};
      hold_cnt_q  <= {HOLD_W{1'b0}};
    end else begin
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      sel_valid_q <= sel_valid_d;
      ptr_q       <= ptr_d;
      turn_cnt_q  <= turn_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // The pad only follows io_mux while an owner is established; sel is stable then.
  assign mux_if.pad_o     = mux_if.mux_o;
  assign mux_if.pad_t     = (state_q == OWN) ? mux_if.mux_t : 1'b1;
  assign mux_if.gnt       = gnt_q;
  assign mux_if.sel       = sel_q;
  assign mux_if.sel_valid = sel_valid_q;

endmodule

// File: tb/tb_io_mux_arbiter.sv
// Directed bench for io_mux_arbiter: default, preempting and 3-pin instances.
module tb_io_mux_arbiter;

  logic clk;
  logic rst;
  int   total_cnt;
  int   pass_cnt;
  int   exp_owner;
  logic [7:0] mask;

  io_mux_arbiter_if #(.N(8)) if_a ();
  io_mux_arbiter_if #(.N(8)) if_p ();
  io_mux_arbiter_if #(.N(3)) if_w ();

  io_mux_arbiter #(.C_NUM_OF_PIN(8), .C_TURNAROUND(2), .C_MAX_HOLD(0)) u_a (
    .clk(clk), .rst(rst), .mux_if(if_a)
  );
  io_mux_arbiter #(.C_NUM_OF_PIN(8), .C_TURNAROUND(2), .C_MAX_HOLD(4)) u_p (
    .clk(clk), .rst(rst), .mux_if(if_p)
  );
  io_mux_arbiter #(.C_NUM_OF_PIN(3), .C_TURNAROUND(2), .C_MAX_HOLD(0)) u_w (
    .clk(clk), .rst(rst), .mux_if(if_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst = 1'b1;
    if_a.req = 8'hFF; if_a.mux_o = 1'b1; if_a.mux_t = 1'b0;
    if_p.req = 8'hFF; if_p.mux_o = 1'b1; if_p.mux_t = 1'b0;
    if_w.req = 3'b111; if_w.mux_o = 1'b1; if_w.mux_t = 1'b0;
    tick();
    tick();

    // Reset with all requests high.
    check("rst_gnt", 32'(if_a.gnt), 32'h0);
    check("rst_sel", 32'(if_a.sel), 32'd0);
    check("rst_valid", 32'(if_a.sel_valid), 32'd0);
    check("rst_pad_t", 32'(if_a.pad_t), 32'd1);
    check("rst_pad_o", 32'(if_a.pad_o), 32'd1);
    if_a.mux_o = 1'b0;
    #1;
    check("pad_o_pass", 32'(if_a.pad_o), 32'd0);
    check("rst_p_gnt", 32'(if_p.gnt), 32'h0);
    check("rst_w_gnt", 32'(if_w.gnt), 32'h0);

    // Single request.
    if_p.req = 8'h00;
    if_w.req = 3'b000;
    if_a.req = 8'h04;
    rst = 1'b0;
    tick();
    check("single_gnt", 32'(if_a.gnt), 32'h04);
    check("single_sel", 32'(if_a.sel), 32'd2);
    check("single_valid", 32'(if_a.sel_valid), 32'd1);
    check("single_pad_t0", 32'(if_a.pad_t), 32'd0);
    if_a.mux_t = 1'b1;
    #1;
    check("single_pad_t1", 32'(if_a.pad_t), 32'd1);
    if_a.mux_t = 1'b0;
    tick();
    check("single_hold", 32'(if_a.gnt), 32'h04);
    if_a.req = 8'h00;
    tick();
    check("rel_gnt", 32'(if_a.gnt), 32'h0);
    check("rel_sel_kept", 32'(if_a.sel), 32'd2);
    check("rel_valid", 32'(if_a.sel_valid), 32'd0);
    check("rel_pad_t_c1", 32'(if_a.pad_t), 32'd1);
    tick();
    check("rel_pad_t_c2", 32'(if_a.pad_t), 32'd1);
    tick();
    check("idle_gnt", 32'(if_a.gnt), 32'h0);

    // Round-robin over all eight requesters from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_a.req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      exp_owner = k % 8;
      check("rr_gnt", 32'(if_a.gnt), 32'h1 << exp_owner);
      check("rr_sel", 32'(if_a.sel), 32'(exp_owner));
      if (k < 8) begin
        tick();
        tick();
        mask = 8'hFF ^ (8'h01 << exp_owner);
        if_a.req = mask;
        tick();
        check("rr_turn_gnt", 32'(if_a.gnt), 32'h0);
        check("rr_turn_pad_t", 32'(if_a.pad_t), 32'd1);
        if_a.req = 8'hFF;
        tick();
        tick();
      end
    end

    // Release and new request on the same edge.
    if_a.req = 8'h01;
    tick();
    check("same_own0", 32'(if_a.gnt), 32'h01);
    if_a.req = 8'h40;
    tick();
    check("same_turn1_gnt", 32'(if_a.gnt), 32'h0);
    check("same_turn1_sel", 32'(if_a.sel), 32'd0);
    tick();
    check("same_turn2_gnt", 32'(if_a.gnt), 32'h0);
    tick();
    check("same_new_gnt", 32'(if_a.gnt), 32'h40);
    check("same_new_sel", 32'(if_a.sel), 32'd6);

    // Reset while owner 5 holds the pad.
    if_a.req = 8'h20;
    tick();
    tick();
    tick();
    check("mid_own_sel", 32'(if_a.sel), 32'd5);
    rst = 1'b1;
    tick();
    check("mid_own_rst_gnt", 32'(if_a.gnt), 32'h0);
    check("mid_own_rst_sel", 32'(if_a.sel), 32'd0);
    check("mid_own_rst_valid", 32'(if_a.sel_valid), 32'd0);
    check("mid_own_rst_pad_t", 32'(if_a.pad_t), 32'd1);
    rst = 1'b0;
    tick();
    check("post_rst_gnt", 32'(if_a.gnt), 32'h20);

    // Reset during turnaround.
    if_a.req = 8'h00;
    tick();
    check("mid_turn_gnt", 32'(if_a.gnt), 32'h0);
    rst = 1'b1;
    tick();
    check("mid_turn_rst_gnt", 32'(if_a.gnt), 32'h0);
    check("mid_turn_rst_sel", 32'(if_a.sel), 32'd0);
    check("mid_turn_rst_pad_t", 32'(if_a.pad_t), 32'd1);
    rst = 1'b0;
    if_a.req = 8'h02;
    tick();
    check("after_turn_rst_gnt", 32'(if_a.gnt), 32'h02);
    check("after_turn_rst_sel", 32'(if_a.sel), 32'd1);

    // Preemption after four OWN cycles.
    if_p.req = 8'h02;
    tick();
    check("pre_own_gnt", 32'(if_p.gnt), 32'h02);
    if_p.req = 8'h22;
    tick();
    check("pre_hold1", 32'(if_p.gnt), 32'h02);
    tick();
    check("pre_hold2", 32'(if_p.gnt), 32'h02);
    tick();
    check("pre_hold3", 32'(if_p.gnt), 32'h02);
    tick();
    check("pre_cut_gnt", 32'(if_p.gnt), 32'h0);
    check("pre_cut_pad_t", 32'(if_p.pad_t), 32'd1);
    check("pre_cut_sel", 32'(if_p.sel), 32'd1);
    tick();
    check("pre_turn2_gnt", 32'(if_p.gnt), 32'h0);
    tick();
    check("pre_new_gnt", 32'(if_p.gnt), 32'h20);
    check("pre_new_sel", 32'(if_p.sel), 32'd5);

    // Three-pin instance: pointer wrap after owner 2.
    if_w.req = 3'b100;
    tick();
    check("w_own2_sel", 32'(if_w.sel), 32'd2);
    if_w.req = 3'b000;
    tick();
    if_w.req = 3'b101;
    tick();
    tick();
    check("w_wrap_gnt", 32'(if_w.gnt), 32'h1);
    check("w_wrap_sel", 32'(if_w.sel), 32'd0);
    if_w.req = 3'b010;
    tick();
    tick();
    tick();
    check("w_own1_sel", 32'(if_w.sel), 32'd1);
    if_w.req = 3'b001;
    tick();
    tick();
    tick();
    check("w_search_wrap_gnt", 32'(if_w.gnt), 32'h1);
    check("w_search_wrap_sel", 32'(if_w.sel), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/io_mux_arbiter.md
# io_mux_arbiter

Ownership controller for a shared pad multiplexed among up to 16 logical peripherals. It drives `io_mux`'s select, and handles grants to peripheral requesters by round-robin arbitration. It gates the pad tri-state control so that ownership changes never glitch the pad. It sits between the peripherals' request lines, the `io_mux` select input and the physical pad buffer.

## Interface
Parameters:
- `C_NUM_OF_PIN`, 8: number of logical requesters. Legal range 1..16.
- `C_TURNAROUND`, 2: forced high-Z cycles between owners. Minimum 1.
- `C_MAX_HOLD`, 0: maximum cycles one owner keeps the pad while others wait. 0 disables preemption.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  C_NUM_OF_PIN  per-peripheral request to own the pad. Level signal.
- `gnt`  out  C_NUM_OF_PIN  one-hot or zero. High while that peripheral owns the pad.
- `sel`  out  4  select to `io_mux`. Registered.
- `sel_valid`  out  1  high while in OWN.
- `mux_o`  in  1  `ro` from `io_mux`.
- `mux_t`  in  1  `rt` from `io_mux` (1 = high-Z).
- `pad_o`  out  1  to pad buffer O.
- `pad_t`  out  1  to pad buffer T.

## Operation
States are IDLE, OWN and TURN.

- **Reset values:** state IDLE, `gnt`=0, `sel`=0, `sel_valid`=0, `pad_t`=1, rr pointer=0, turnaround counter=0, hold counter=0.
- **Pad outputs:**
  - `pad_o` = `mux_o`, combinational pass-through.
  - `pad_t` = `mux_t` in OWN, else forced 1.
- **IDLE:**
  - If any `req` bit is high at the clock edge, go to OWN.
  - Winner is the first set bit at or after the rr pointer, searching upward and wrapping modulo `C_NUM_OF_PIN`.
  - Register `sel`=winner and `gnt`=onehot(winner), set `sel_valid`=1, clear the hold counter.
- **OWN, owner releases:** if `req[sel]`=0 at the edge, go to TURN.
  - `gnt`=0, `sel_valid`=0.
  - `sel` holds the old owner.
  - Load the turnaround counter with `C_TURNAROUND`-1.
  - Set the rr pointer to `sel`+1 mod `C_NUM_OF_PIN`.
- **OWN, preemption:** applies when `C_MAX_HOLD`≠0, the hold counter equals `C_MAX_HOLD`-1, and any other `req` bit is high.
  - Go to TURN with the same actions as a release, even though `req[sel]` is still high.
  - Otherwise the hold counter increments, saturating at `C_MAX_HOLD`-1.
- **TURN:** the counter decrements each cycle. When it reaches 0:
  - If any `req` is high, arbitrate exactly as in IDLE and go to OWN.
  - Otherwise go to IDLE.
- **Ignored requests:** `req` bits at index ≥ `C_NUM_OF_PIN` do not exist. `sel` never exceeds `C_NUM_OF_PIN`-1.
- **Release and new request on the same edge:** TURN is still entered. The new request waits out the turnaround.
- **Reset mid-OWN or mid-TURN:** all state returns to reset values on the next edge. `pad_t`=1 from that edge.

## Timing
- `req` rises in IDLE at edge N → `gnt`/`sel`/`sel_valid` valid after edge N. Latency is 1 cycle.
- Owner drops `req` before edge N → `gnt`=0 after edge N. `pad_t` is forced to 1 after edge N, for exactly `C_TURNAROUND` cycles.
- The next `gnt` asserts after edge N+`C_TURNAROUND`.
- `sel` changes only on entry to OWN. It is never updated while `pad_t` follows `mux_t`.
- `gnt` and `sel` are never both changing while `sel_valid`=1.

## Structure
- **Package `io_mux_pkg`:**
  - state enum (IDLE=2'd0, OWN=2'd1, TURN=2'd2);
  - `SEL_W`=4;
  - `MAX_PINS`=16.
- **Sub-module `rr_pick`:** combinational. Inputs are the request vector and the pointer. Outputs are `any` and the winner index (`SEL_W`). This is a rotate, then priority-encode, then un-rotate.
- **Top:** state register, counters, rr pointer, output registers and `pad_t` gating.

## Test plan
- **Reset:** assert `rst` with `req`=8'hFF → `gnt`=0, `sel`=0, `sel_valid`=0, `pad_t`=1 while `mux_t`=0.
- **Single request:** `req`=8'h04 from IDLE → after 1 edge, `gnt`=8'h04, `sel`=2, `pad_t` follows `mux_t`. Drop `req` → `pad_t`=1 for exactly 2 cycles, then IDLE.
- **Round-robin:** `req`=8'hFF, each owner holds 3 cycles then pulses low 1 cycle → grant order 0,1,2,…,7,0.
- **Preemption:** `C_MAX_HOLD`=4, `req[1]` held, `req[5]` rises → owner 1 is cut after 4 OWN cycles, 2 TURN cycles, then `gnt`=8'h20.
- **Edge cases:**
  - Release and a new request on the same edge → new owner after `C_TURNAROUND`.
  - `C_NUM_OF_PIN`=3, wrap case: `req`=3'b101, prior owner 2 → next owner 0.
- **Mid-operation reset:** reset during OWN (`sel`=5) and during TURN → next cycle matches the reset values, and no `gnt` glitch.
